// File: rtl/snn_pkg.sv
// Shared QS2.13 fixed-point constants, saturation helper and layer FSM states
// used by the spiking network layers.
package snn_pkg;

    localparam int unsigned QS_W     = 16;
    localparam int unsigned QS_FRAC  = 13;
    localparam int unsigned QS_SUM_W = QS_W + 2;

    localparam logic signed [QS_W-1:0] QS_MAX = 16'sh7FFF;
    localparam logic signed [QS_W-1:0] QS_MIN = 16'sh8000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECEIVE = 2'd1,
        REPORT  = 2'd2
    } state_e;

    // Clamp a widened QS2.13 sum back into the representable range.
    function automatic logic signed [QS_W-1:0] saturate(input logic signed [QS_SUM_W-1:0] s);
        if (s > QS_SUM_W'(QS_MAX)) begin
            return QS_MAX;
        end
        if (s < QS_SUM_W'(QS_MIN)) begin
            return QS_MIN;
        end
        return QS_W'(s);
    endfunction

endpackage

// File: rtl/lif_update.sv
// Combinational leaky integrate-and-fire step: decay, integrate, saturate,
// threshold and reset-by-subtraction for one membrane.
module lif_update
    import snn_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = QS_W,
    parameter int unsigned FRAC_BITS  = QS_FRAC
) (
    input  logic signed [DATA_WIDTH-1:0] mem_i,
    input  logic signed [DATA_WIDTH-1:0] current_i,
    input  logic signed [DATA_WIDTH-1:0] beta_i,
    input  logic signed [DATA_WIDTH-1:0] threshold_i,
    output logic signed [DATA_WIDTH-1:0] stored_o,
    output logic                         spike_o
);

    localparam int unsigned PROD_W = 2 * DATA_WIDTH;
    localparam int unsigned SUM_W  = DATA_WIDTH + 2;

    logic signed [PROD_W-1:0]     prod;
    logic signed [DATA_WIDTH-1:0] decayed;
    logic signed [SUM_W-1:0]      sum;
    logic signed [DATA_WIDTH-1:0] sat_sum;
    logic                         fits;

    always_comb begin
        prod    = PROD_W'(beta_i) * PROD_W'(mem_i);
        decayed = DATA_WIDTH'(prod >>> FRAC_BITS);
        sum     = SUM_W'(decayed) + SUM_W'(current_i);
        // The sum fits when all bits above the target sign bit agree with it.
        fits    = (sum[SUM_W-1:DATA_WIDTH-1] == '0) || (sum[SUM_W-1:DATA_WIDTH-1] == '1);
        if (fits) begin
            sat_sum = DATA_WIDTH'(sum);
        end else begin
            sat_sum = {sum[SUM_W-1], {(DATA_WIDTH-1){~sum[SUM_W-1]}}};
        end
        spike_o  = (sat_sum >= threshold_i);
        stored_o = spike_o ? (sat_sum - threshold_i) : sat_sum;
    end

endmodule

// File: rtl/lif_neuron_layer.sv
// Serial LIF neuron layer: integrates one indexed synaptic current per cycle,
// emits per-sample spikes and a framed spike vector with an integrity flag.
module lif_neuron_layer
    import snn_pkg::*;
#(
    parameter int unsigned              NUM_NEURONS = 16,
    parameter int unsigned              DATA_WIDTH  = QS_W,
    parameter int unsigned              FRAC_BITS   = QS_FRAC,
    parameter logic signed [DATA_WIDTH-1:0] BETA      = 16'sd7373,
    parameter logic signed [DATA_WIDTH-1:0] THRESHOLD = 16'sd8192
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             clear_state,
    input  logic signed [DATA_WIDTH-1:0]     in_current,
    input  logic [$clog2(NUM_NEURONS)-1:0]   in_idx,
    input  logic                             in_valid,
    input  logic                             in_done,
    output logic                             spike_out,
    output logic [$clog2(NUM_NEURONS)-1:0]   spike_idx,
    output logic signed [DATA_WIDTH-1:0]     membrane_out,
    output logic                             spike_valid,
    output logic [NUM_NEURONS-1:0]           spikes,
    output logic                             spikes_valid,
    output logic                             frame_error
);

    localparam int unsigned    IDX_W = $clog2(NUM_NEURONS);
    localparam logic [IDX_W:0] NUM_N = (IDX_W + 1)'(NUM_NEURONS);

    state_e                       state_q;
    logic signed [DATA_WIDTH-1:0] mem_q [NUM_NEURONS];
    logic [NUM_NEURONS-1:0]       recv_q;
    logic [NUM_NEURONS-1:0]       spikes_q;
    logic                         dup_q;
    logic                         bad_q;
    logic                         spike_out_q;
    logic [IDX_W-1:0]             spike_idx_q;
    logic signed [DATA_WIDTH-1:0] membrane_q;
    logic                         spike_valid_q;
    logic                         spikes_valid_q;
    logic                         frame_error_q;

    logic                         idx_ok;
    logic                         accept;
    logic                         new_frame;
    logic signed [DATA_WIDTH-1:0] mem_prior;
    logic signed [DATA_WIDTH-1:0] stored;
    logic                         spike;
    logic [NUM_NEURONS-1:0]       recv_d;
    logic [NUM_NEURONS-1:0]       spikes_d;
    logic                         dup_d;
    logic                         bad_d;
    logic                         frame_err_d;

    lif_update #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS)
    ) u_lif_update (
        .mem_i       (mem_prior),
        .current_i   (in_current),
        .beta_i      (BETA),
        .threshold_i (THRESHOLD),
        .stored_o    (stored),
        .spike_o     (spike)
    );

    // Frame bookkeeping; any sample outside RECEIVE opens a fresh frame.
    always_comb begin
        idx_ok    = ({1'b0, in_idx} < NUM_N);
        accept    = in_valid && idx_ok;
        new_frame = in_valid && (state_q != RECEIVE);
        mem_prior = clear_state ? '0 : mem_q[in_idx];

        recv_d   = new_frame ? '0 : recv_q;
        spikes_d = new_frame ? '0 : spikes_q;
        dup_d    = new_frame ? 1'b0 : dup_q;
        bad_d    = new_frame ? 1'b0 : bad_q;

        if (accept) begin
            dup_d            = dup_d | recv_d[in_idx];
            recv_d[in_idx]   = 1'b1;
            spikes_d[in_idx] = spike;
        end else if (in_valid) begin
            bad_d = 1'b1;
        end

        frame_err_d = (~&recv_d) | dup_d | bad_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            for (int n = 0; n < NUM_NEURONS; n++) begin
                mem_q[n] <= '0;
            end
            recv_q         <= '0;
            spikes_q       <= '0;
            dup_q          <= 1'b0;
            bad_q          <= 1'b0;
            spike_out_q    <= 1'b0;
            spike_idx_q    <= '0;
            membrane_q     <= '0;
            spike_valid_q  <= 1'b0;
            spikes_valid_q <= 1'b0;
            frame_error_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, REPORT: begin
                    if (in_valid) begin
                        state_q <= in_done ? REPORT : RECEIVE;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RECEIVE: begin
                    if (in_valid && in_done) begin
                        state_q <= REPORT;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (clear_state) begin
                for (int n = 0; n < NUM_NEURONS; n++) begin
                    mem_q[n] <= '0;
                end
            end
            if (accept) begin
                mem_q[in_idx] <= stored;
                spike_out_q   <= spike;
                spike_idx_q   <= in_idx;
                membrane_q    <= stored;
            end
            spike_valid_q <= accept;

            recv_q   <= recv_d;
            spikes_q <= spikes_d;
            dup_q    <= dup_d;
            bad_q    <= bad_d;

            // Report strobe is high during the REPORT state that follows in_done.
            spikes_valid_q <= in_valid && in_done;
            frame_error_q  <= (in_valid && in_done) ? frame_err_d : 1'b0;
        end
    end

    assign spike_out    = spike_out_q;
    assign spike_idx    = spike_idx_q;
    assign membrane_out = membrane_q;
    assign spike_valid  = spike_valid_q;
    assign spikes       = spikes_q;
    assign spikes_valid = spikes_valid_q;
    assign frame_error  = frame_error_q;

endmodule

// File: tb/tb_lif_neuron_layer.sv
// Directed bench for lif_neuron_layer with hand-computed QS2.13 expectations.
module tb_lif_neuron_layer;

    logic               clk;
    logic               reset;
    logic               clear_state;
    logic signed [15:0] in_current;
    logic [3:0]         in_idx;
    logic               in_valid;
    logic               in_done;
    logic               spike_out;
    logic [3:0]         spike_idx;
    logic signed [15:0] membrane_out;
    logic               spike_valid;
    logic [15:0]        spikes;
    logic               spikes_valid;
    logic               frame_error;

    int n_checks = 0;
    int n_fail   = 0;

    lif_neuron_layer dut (
        .clk          (clk),
        .reset        (reset),
        .clear_state  (clear_state),
        .in_current   (in_current),
        .in_idx       (in_idx),
        .in_valid     (in_valid),
        .in_done      (in_done),
        .spike_out    (spike_out),
        .spike_idx    (spike_idx),
        .membrane_out (membrane_out),
        .spike_valid  (spike_valid),
        .spikes       (spikes),
        .spikes_valid (spikes_valid),
        .frame_error  (frame_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input int idx, input logic signed [15:0] cur, input bit done, input bit clr);
        @(negedge clk);
        in_valid    = 1'b1;
        in_idx      = 4'(idx);
        in_current  = cur;
        in_done     = done;
        clear_state = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        @(negedge clk);
        in_valid    = 1'b0;
        in_done     = 1'b0;
        clear_state = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_done     = 1'b0;
        clear_state = 1'b0;
        in_idx      = '0;
        in_current  = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Idx 0..15 in order, optional skipped index and duplicated index; done on 15.
    task automatic run_frame(input string name, input logic signed [15:0] cur,
                             input int skip, input int dup, input bit chk_mem,
                             input logic signed [15:0] exp_mem, input logic exp_spk,
                             input logic [15:0] exp_vec, input logic exp_err);
        for (int i = 0; i < 16; i++) begin
            if (i == skip) continue;
            for (int r = 0; r < ((i == dup) ? 2 : 1); r++) begin
                send(i, cur, (i == 15), 1'b0);
                n_checks++;
                if (spike_valid !== 1'b1 || spike_idx !== 4'(i)) begin
                    n_fail++;
                    $display("FAIL %s sample %0d: spike_valid=%b idx=%0d, want 1 idx=%0d",
                             name, i, spike_valid, spike_idx, i);
                end
                if (chk_mem) begin
                    n_checks++;
                    if (membrane_out !== exp_mem || spike_out !== exp_spk) begin
                        n_fail++;
                        $display("FAIL %s sample %0d: membrane=%0d spike=%b, want %0d %b",
                                 name, i, membrane_out, spike_out, exp_mem, exp_spk);
                    end
                end
                if (i != 15) begin
                    n_checks++;
                    if (spikes_valid !== 1'b0) begin
                        n_fail++;
                        $display("FAIL %s early spikes_valid at sample %0d: got %b want 0",
                                 name, i, spikes_valid);
                    end
                end
            end
        end
        n_checks++;
        if (spikes_valid !== 1'b1 || spikes !== exp_vec || frame_error !== exp_err) begin
            n_fail++;
            $display("FAIL %s report: valid=%b spikes=%h err=%b, want 1 %h %b",
                     name, spikes_valid, spikes, frame_error, exp_vec, exp_err);
        end
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        clear_state = 1'b0;
        in_valid    = 1'b0;
        in_done     = 1'b0;
        in_idx      = '0;
        in_current  = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({spike_out, spike_idx, membrane_out, spike_valid, spikes, spikes_valid, frame_error} !== '0) begin
            n_fail++;
            $display("FAIL reset outputs: so=%b idx=%0d mem=%0d sv=%b spikes=%h ssv=%b err=%b, want all 0",
                     spike_out, spike_idx, membrane_out, spike_valid, spikes, spikes_valid, frame_error);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_frames();
        run_frame("frame1", 16'sd4096, -1, -1, 1'b1, 16'sd4096, 1'b0, 16'h0000, 1'b0);
        go_idle();
        @(posedge clk);
        #1;
        n_checks++;
        if (spikes_valid !== 1'b0 || spike_valid !== 1'b0 || spikes !== 16'h0000) begin
            n_fail++;
            $display("FAIL report pulse width: spikes_valid=%b spike_valid=%b spikes=%h, want 0 0 0000",
                     spikes_valid, spike_valid, spikes);
        end
        run_frame("frame2", 16'sd4096, -1, -1, 1'b1, 16'sd7782, 1'b0, 16'h0000, 1'b0);
        run_frame("frame3", 16'sd4096, -1, -1, 1'b1, 16'sd2907, 1'b1, 16'hFFFF, 1'b0);
        go_idle();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (spikes !== 16'hFFFF || spikes_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL spikes hold: spikes=%h valid=%b, want FFFF 0", spikes, spikes_valid);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        run_frame("sat_pre1", 16'sd4096, -1, -1, 1'b1, 16'sd4096, 1'b0, 16'h0000, 1'b0);
        run_frame("sat_pre2", 16'sd4096, -1, -1, 1'b1, 16'sd7782, 1'b0, 16'h0000, 1'b0);
        send(0, 16'sd32767, 1'b0, 1'b0);
        n_checks++;
        if (membrane_out !== 16'sd24575 || spike_out !== 1'b1 || spike_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_pos: membrane=%0d spike=%b valid=%b, want 24575 1 1",
                     membrane_out, spike_out, spike_valid);
        end
        do_reset();
        for (int k = 0; k < 2; k++) begin
            send(2, -16'sd32768, 1'b0, 1'b0);
            n_checks++;
            if (membrane_out !== -16'sd32768 || spike_out !== 1'b0 || spike_idx !== 4'd2) begin
                n_fail++;
                $display("FAIL sat_neg pass %0d: membrane=%0d spike=%b idx=%0d, want -32768 0 2",
                         k, membrane_out, spike_out, spike_idx);
            end
        end
        go_idle();
    endtask

    task automatic test_frame_error();
        do_reset();
        run_frame("skip7", 16'sd4096, 7, -1, 1'b1, 16'sd4096, 1'b0, 16'h0000, 1'b1);
        // Neuron 3 goes 4096 -> 7782 -> 11099 on its repeat and fires.
        run_frame("dup3", 16'sd4096, -1, 3, 1'b0, 16'sd0, 1'b0, 16'h0008, 1'b1);
        go_idle();
    endtask

    task automatic test_clear();
        do_reset();
        run_frame("clr_pre1", 16'sd4096, -1, -1, 1'b1, 16'sd4096, 1'b0, 16'h0000, 1'b0);
        run_frame("clr_pre2", 16'sd4096, -1, -1, 1'b1, 16'sd7782, 1'b0, 16'h0000, 1'b0);
        @(negedge clk);
        in_valid    = 1'b0;
        in_done     = 1'b0;
        clear_state = 1'b1;
        go_idle();
        run_frame("clr_after", 16'sd4096, -1, -1, 1'b1, 16'sd4096, 1'b0, 16'h0000, 1'b0);
        send(5, 16'sd1000, 1'b0, 1'b1);
        n_checks++;
        if (membrane_out !== 16'sd1000 || spike_out !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_coincident: membrane=%0d spike=%b, want 1000 0", membrane_out, spike_out);
        end
        send(6, 16'sd4096, 1'b0, 1'b0);
        n_checks++;
        if (membrane_out !== 16'sd4096) begin
            n_fail++;
            $display("FAIL clr_neighbor: membrane=%0d, want 4096", membrane_out);
        end
        go_idle();
    endtask

    task automatic test_reset_midframe();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send(i, 16'sd4096, 1'b0, 1'b0);
        end
        #3;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({spike_out, spike_idx, membrane_out, spike_valid, spikes, spikes_valid, frame_error} !== '0) begin
            n_fail++;
            $display("FAIL midframe reset: so=%b idx=%0d mem=%0d sv=%b spikes=%h ssv=%b err=%b, want all 0",
                     spike_out, spike_idx, membrane_out, spike_valid, spikes, spikes_valid, frame_error);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_done  = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        run_frame("post_reset", 16'sd4096, -1, -1, 1'b1, 16'sd4096, 1'b0, 16'h0000, 1'b0);
    endtask

    // Sample arriving during REPORT opens the next frame without being lost.
    task automatic test_back_to_back();
        run_frame("b2b_first", 16'sd4096, -1, -1, 1'b1, 16'sd7782, 1'b0, 16'h0000, 1'b0);
        send(0, 16'sd4096, 1'b0, 1'b0);
        n_checks++;
        if (spike_valid !== 1'b1 || spike_out !== 1'b1 || membrane_out !== 16'sd2907 ||
            spikes_valid !== 1'b0 || spikes !== 16'h0001) begin
            n_fail++;
            $display("FAIL b2b_report_sample: sv=%b so=%b mem=%0d ssv=%b spikes=%h, want 1 1 2907 0 0001",
                     spike_valid, spike_out, membrane_out, spikes_valid, spikes);
        end
        for (int i = 1; i < 16; i++) begin
            send(i, 16'sd4096, (i == 15), 1'b0);
            n_checks++;
            if (membrane_out !== 16'sd2907 || spike_out !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b sample %0d: membrane=%0d spike=%b, want 2907 1", i, membrane_out, spike_out);
            end
        end
        n_checks++;
        if (spikes_valid !== 1'b1 || spikes !== 16'hFFFF || frame_error !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b report: valid=%b spikes=%h err=%b, want 1 FFFF 0",
                     spikes_valid, spikes, frame_error);
        end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_frames();
        test_saturation();
        test_frame_error();
        test_clear();
        test_reset_midframe();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lif_neuron_layer.md
Name: lif_neuron_layer

Overview:
Consumer of the serial current stream produced by the fully connected layer. Each cycle accepts one QS2.13 synaptic current tagged with a neuron index and updates that neuron's leaky integrate-and-fire membrane. It emits a per-sample spike and, at end of frame, a registered spike vector for the next layer. Membranes persist across frames (timesteps) until cleared.

Parameters:
NUM_NEURONS, 16, neurons in layer (must equal upstream NUM_OUTPUTS)
DATA_WIDTH, 16, signed fixed-point width
FRAC_BITS, 13, fractional bits (QS2.13)
BETA, 16'sd7373, membrane decay factor (0.9), signed, 0 <= BETA < 1.0
THRESHOLD, 16'sd8192, firing threshold (1.0), must be > 0

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
clear_state  input  1  zero all membranes (synchronous)
in_current  input  DATA_WIDTH signed  synaptic current for in_idx
in_idx  input  $clog2(NUM_NEURONS)  target neuron
in_valid  input  1  in_current/in_idx valid this cycle
in_done  input  1  last sample of frame; only meaningful with in_valid
spike_out  output  1  spike for spike_idx
spike_idx  output  $clog2(NUM_NEURONS)  neuron of spike_out
membrane_out  output  DATA_WIDTH signed  post-update stored membrane of spike_idx
spike_valid  output  1  spike_out/spike_idx/membrane_out valid
spikes  output  NUM_NEURONS  frame spike vector, bit n = neuron n
spikes_valid  output  1  one-cycle pulse: spikes complete
frame_error  output  1  valid with spikes_valid: frame incomplete or duplicated

Behaviour:
- Reset (async, any time incl. mid-frame): all membranes 0, all outputs 0, state IDLE, received mask 0.
- Datapath per accepted sample (in_valid, in_idx < NUM_NEURONS):
  - decayed = (BETA * mem[in_idx]) >>> FRAC_BITS (2*DATA_WIDTH product, arithmetic shift, floor).
  - sum = decayed + in_current at DATA_WIDTH+2 bits; saturate to [-32768, 32767].
  - spike = (sat_sum >= THRESHOLD); stored = spike ? sat_sum - THRESHOLD : sat_sum (reset by subtraction; no overflow possible).
  - mem[in_idx] <= stored; spikes[in_idx] <= spike; received[in_idx] <= 1 (duplicate if already set).
- Latency: 1 cycle. spike_valid/spike_out/spike_idx/membrane_out registered in cycle after sample; spike_valid low otherwise; other per-sample outputs hold.
- in_idx >= NUM_NEURONS: sample dropped, no spike_valid, marks frame error.
- FSM:
  - IDLE: spikes_valid 0. On in_valid: process sample, clear received mask then set this bit, clear spikes vector then set this bit; -> RECEIVE (or -> REPORT if in_done also set).
  - RECEIVE: process each in_valid; gaps allowed. in_valid && in_done -> REPORT.
  - REPORT: spikes_valid=1 for exactly one cycle; frame_error = (received != all ones) || duplicate || bad index seen; -> IDLE. spikes holds until next frame's first sample.
  - in_valid in REPORT: processed as first sample of new frame (IDLE semantics, -> RECEIVE/REPORT); upstream contiguous streams never do this but must not be lost.
- in_done without in_valid: ignored.
- clear_state: all membranes zeroed that cycle; a coincident sample uses mem = 0 as its prior value and its result is stored. Does not alter FSM, spikes, or mask.

Decomposition:
- Shared package snn_pkg: QS2.13 width/frac constants, saturation MIN/MAX, a saturate function, state enum (IDLE, RECEIVE, REPORT). Shared with the linear layer.
- One sub-module: lif_update (combinational: mem, current, BETA, THRESHOLD -> stored, spike). Reusable by a future parallel LIF layer.

Test Plan:
- Reset, frame of 16 samples in_current=4096 idx 0..15, in_done on 15 -> each spike_valid with spike_out=0, membrane_out=4096; next cycle spikes_valid=1, spikes=16'h0000, frame_error=0.
- Repeat frames of 4096 -> frame 2 membrane 7782, no spike; frame 3 sum 11099, spike_out=1, membrane_out=2907, spikes=16'hFFFF.
- Neuron at 7782 given 32767 -> saturates 32767, spike=1, membrane_out=24575; given -32768 from 0 twice -> membrane -32768 both times, no spike.
- Frame skipping idx 7 (15 samples, done on idx 15) -> spikes_valid=1, frame_error=1; frame with idx 3 sent twice -> frame_error=1.
- clear_state between frames after membrane 7782 -> next 4096 sample gives membrane_out=4096; clear coincident with sample -> membrane_out=in_current.
- Assert reset mid-frame after 5 samples -> all outputs 0 immediately; new full frame behaves as first scenario.
